// File: rtl/fetch_stage_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, reset vector and NOP encoding.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one outstanding request, delay-slot branch redirect and flush.
// Define FETCH_ADDR_ERR_EN to deliver misaligned-PC faults through the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef FETCH_ADDR_ERR_EN
    ,
    output logic        fetch_addr_err
`endif
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic         redirect_r, redirect_s;
    logic [31:0]  target_r, target_s;
    logic         discard_r, discard_s;
    logic [31:0]  hold_inst_r, hold_inst_s;
    logic         id_valid_r, id_valid_s;
    logic [31:0]  id_pc_r, id_pc_s;
    logic [31:0]  id_inst_r, id_inst_s;
    logic         inst_req_r, inst_req_s;
    logic [31:0]  inst_addr_r, inst_addr_s;
    logic         deliver_s;
    logic [31:0]  deliver_inst_s;
    logic         taken_s;
    logic         accept_s;
`ifdef FETCH_ADDR_ERR_EN
    logic         id_err_r, id_err_s;
    logic         deliver_err_s;
`endif

    // Next-state, PC and IF/ID register computation
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        redirect_s     = redirect_r;
        target_s       = target_r;
        discard_s      = discard_r;
        hold_inst_s    = hold_inst_r;
        id_valid_s     = id_valid_r;
        id_pc_s        = id_pc_r;
        id_inst_s      = id_inst_r;
        deliver_s      = 1'b0;
        deliver_inst_s = NOP_INST;
`ifdef FETCH_ADDR_ERR_EN
        id_err_s       = id_err_r;
        deliver_err_s  = 1'b0;
`endif
        taken_s  = branch_taken & ~stall;
        accept_s = inst_req_r & inst_addr_ok;

        if (flush) begin
            pc_s        = flush_pc;
            redirect_s  = 1'b0;
            hold_inst_s = NOP_INST;
            id_valid_s  = 1'b0;
`ifdef FETCH_ADDR_ERR_EN
            id_err_s    = 1'b0;
`endif
            // A request accepted this very cycle still owes a response, so it must be discarded.
            case (state_r)
                FS_REQ: begin
                    state_s   = accept_s ? FS_WAIT : FS_REQ;
                    discard_s = accept_s;
                end
                FS_WAIT: begin
                    state_s   = inst_data_ok ? FS_REQ : FS_WAIT;
                    discard_s = ~inst_data_ok;
                end
                default: begin
                    state_s   = FS_REQ;
                    discard_s = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                FS_REQ: begin
`ifdef FETCH_ADDR_ERR_EN
                    if (misaligned(pc_r)) begin
                        deliver_s     = ~stall;
                        deliver_err_s = 1'b1;
                    end else if (accept_s) begin
                        state_s = FS_WAIT;
                    end else begin
                        state_s = FS_REQ;
                    end
`else
                    if (accept_s) begin
                        state_s = FS_WAIT;
                    end else begin
                        state_s = FS_REQ;
                    end
`endif
                end
                FS_WAIT: begin
                    if (!inst_data_ok) begin
                        state_s = FS_WAIT;
                    end else if (discard_r) begin
                        state_s   = FS_REQ;
                        discard_s = 1'b0;
                    end else if (stall) begin
                        state_s     = FS_HOLD;
                        hold_inst_s = inst_rdata;
                    end else begin
                        deliver_s      = 1'b1;
                        deliver_inst_s = inst_rdata;
                    end
                end
                FS_HOLD: begin
                    if (stall) begin
                        state_s = FS_HOLD;
                    end else begin
                        deliver_s      = 1'b1;
                        deliver_inst_s = hold_inst_r;
                        hold_inst_s    = NOP_INST;
                    end
                end
                default: begin
                    state_s = FS_REQ;
                end
            endcase

            // A delivered word is the delay slot of any pending or same-cycle branch.
            if (deliver_s) begin
                state_s    = FS_REQ;
                id_valid_s = 1'b1;
                id_pc_s    = pc_r;
                id_inst_s  = deliver_inst_s;
                redirect_s = 1'b0;
`ifdef FETCH_ADDR_ERR_EN
                id_err_s   = deliver_err_s;
`endif
                if (taken_s) begin
                    pc_s = branch_target;
                end else if (redirect_r) begin
                    pc_s = target_r;
                end else begin
                    pc_s = seq_pc(pc_r);
                end
            end else if (!stall) begin
                id_valid_s = 1'b0;
`ifdef FETCH_ADDR_ERR_EN
                id_err_s   = 1'b0;
`endif
                if (taken_s) begin
                    redirect_s = 1'b1;
                    target_s   = branch_target;
                end else begin
                    redirect_s = redirect_r;
                    target_s   = target_r;
                end
            end else begin
                id_valid_s = id_valid_r;
            end
        end
    end

    // Memory request for the cycle after this one, derived from the next state
    always_comb begin
        inst_req_s  = 1'b0;
        inst_addr_s = pc_s;
`ifdef FETCH_ADDR_ERR_EN
        if ((state_s == FS_REQ) && !misaligned(pc_s)) begin
            inst_req_s = 1'b1;
        end else begin
            inst_req_s = 1'b0;
        end
`else
        inst_addr_s = {pc_s[31:2], 2'b00};
        if (state_s == FS_REQ) begin
            inst_req_s = 1'b1;
        end else begin
            inst_req_s = 1'b0;
        end
`endif
    end

    // State, IF/ID and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FS_REQ;
            pc_r        <= RESET_PC;
            redirect_r  <= 1'b0;
            target_r    <= 32'h0000_0000;
            discard_r   <= 1'b0;
            hold_inst_r <= NOP_INST;
            id_valid_r  <= 1'b0;
            id_pc_r     <= 32'h0000_0000;
            id_inst_r   <= 32'h0000_0000;
            inst_req_r  <= 1'b0;
            inst_addr_r <= RESET_PC;
`ifdef FETCH_ADDR_ERR_EN
            id_err_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            redirect_r  <= redirect_s;
            target_r    <= target_s;
            discard_r   <= discard_s;
            hold_inst_r <= hold_inst_s;
            id_valid_r  <= id_valid_s;
            id_pc_r     <= id_pc_s;
            id_inst_r   <= id_inst_s;
            inst_req_r  <= inst_req_s;
            inst_addr_r <= inst_addr_s;
`ifdef FETCH_ADDR_ERR_EN
            id_err_r    <= id_err_s;
`endif
        end
    end

    assign inst_req  = inst_req_r;
    assign inst_addr = inst_addr_r;
    assign id_valid  = id_valid_r;
    assign id_pc     = id_pc_r;
    assign id_inst   = id_inst_r;
`ifdef FETCH_ADDR_ERR_EN
    assign fetch_addr_err = id_err_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven fetches, scoreboard of delivered words, redirect sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_ADDR_ERR_EN
    logic        fetch_addr_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        int          a_dly;
        int          d_dly;
        int          stall_cyc;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[6];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
`ifdef FETCH_ADDR_ERR_EN
        ,
        .fetch_addr_err(fetch_addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2408_0001 + (a - 32'hBFC0_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (inst_req) break;
            @(negedge clk);
        end
        check("req_seen", {31'd0, inst_req}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        flush = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One complete fetch; stall_cyc>0 freezes ID from request time and parks the word in HOLD.
    task automatic fetch_one(input int a_dly, input int d_dly, input int stall_cyc,
                             input logic [31:0] pc, input logic [31:0] inst);
        wait_req();
        check("req_addr", inst_addr, pc);
        sb_q.push_back({pc, inst});
        if (stall_cyc > 0) stall = 1'b1;
        repeat (a_dly) @(negedge clk);
        check("addr_stable", inst_addr, pc);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        repeat (d_dly) @(negedge clk);
        inst_data_ok = 1'b1;
        inst_rdata = mem_word(pc);
        @(negedge clk);
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0000_0000;
        if (stall_cyc > 0) begin
            check("hold_req", {31'd0, inst_req}, 32'd0);
            check("hold_id_valid", {31'd0, id_valid}, 32'd1);
            check("hold_id_pc", id_pc, pc - 32'd4);
            repeat (stall_cyc - 1) @(negedge clk);
            stall = 1'b0;
            @(negedge clk);
            check("rereq", {31'd0, inst_req}, 32'd1);
            check("rereq_addr", inst_addr, pc + 32'd4);
        end
    endtask

    // Scoreboard: a new IF/ID entry appears whenever id_valid is set after an unstalled edge.
    initial begin
        logic [63:0] exp_e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && id_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: actual pc %h inst %h, required no delivery", id_pc, id_inst);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("sb_pc", id_pc, exp_e[63:32]);
                    check("sb_inst", id_inst, exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{0, 0, 0, 32'hBFC0_0000, 32'h2408_0001};
        vecs[1] = '{0, 0, 0, 32'hBFC0_0004, 32'h2408_0005};
        vecs[2] = '{2, 1, 0, 32'hBFC0_0008, 32'h2408_0009};
        vecs[3] = '{1, 3, 2, 32'hBFC0_000C, 32'h2408_000D};
        vecs[4] = '{0, 0, 3, 32'hBFC0_0010, 32'h2408_0011};
        vecs[5] = '{3, 0, 0, 32'hBFC0_0014, 32'h2408_0015};

        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0000_0000;
        flush = 1'b0;
        flush_pc = 32'h0000_0000;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
`ifdef FETCH_ADDR_ERR_EN
        check("rst_addr_err", {31'd0, fetch_addr_err}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("boot_req", {31'd0, inst_req}, 32'd1);
        check("boot_addr", inst_addr, 32'hBFC0_0000);

        for (int i = 0; i < 6; i++) begin
            fetch_one(vecs[i].a_dly, vecs[i].d_dly, vecs[i].stall_cyc, vecs[i].pc, vecs[i].inst);
        end

        // Branch in ID while 0x08 is in flight: 0x08 is the delay slot, then the target.
        do_reset();
        fetch_one(0, 0, 0, 32'hBFC0_0000, mem_word(32'hBFC0_0000));
        fetch_one(0, 0, 0, 32'hBFC0_0004, mem_word(32'hBFC0_0004));
        wait_req();
        check("br_req_addr", inst_addr, 32'hBFC0_0008);
        sb_q.push_back({32'hBFC0_0008, mem_word(32'hBFC0_0008)});
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'hBFC0_0100;
        @(negedge clk);
        branch_taken = 1'b0;
        branch_target = 32'h0000_0000;
        check("br_wait_noreq", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata = mem_word(32'hBFC0_0008);
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("br_target_req", {31'd0, inst_req}, 32'd1);
        check("br_target_addr", inst_addr, 32'hBFC0_0100);
        fetch_one(0, 0, 0, 32'hBFC0_0100, mem_word(32'hBFC0_0100));

        // Flush (under stall) while waiting for data: response dropped, refetch at flush_pc.
        wait_req();
        check("fl_req_addr", inst_addr, 32'hBFC0_0104);
        stall = 1'b1;
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        check("fl_pre_valid", {31'd0, id_valid}, 32'd1);
        flush = 1'b1;
        flush_pc = 32'hBFC0_0380;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        check("fl_id_valid", {31'd0, id_valid}, 32'd0);
        check("fl_wait_noreq", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("fl_drop_valid", {31'd0, id_valid}, 32'd0);
        check("fl_req", {31'd0, inst_req}, 32'd1);
        check("fl_addr", inst_addr, 32'hBFC0_0380);
        fetch_one(0, 0, 0, 32'hBFC0_0380, mem_word(32'hBFC0_0380));

        // Flush, branch and stall together before acceptance: flush wins, no redirect left.
        check("sim_pre_addr", inst_addr, 32'hBFC0_0384);
        flush = 1'b1;
        flush_pc = 32'hBFC0_0200;
        branch_taken = 1'b1;
        branch_target = 32'hBFC0_0300;
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        check("sim_req", {31'd0, inst_req}, 32'd1);
        check("sim_addr", inst_addr, 32'hBFC0_0200);
        check("sim_id_valid", {31'd0, id_valid}, 32'd0);
        fetch_one(0, 0, 0, 32'hBFC0_0200, mem_word(32'hBFC0_0200));
        check("sim_no_redirect", inst_addr, 32'hBFC0_0204);

        // Flush in the accept cycle, then a second flush while the response is still owed.
        inst_addr_ok = 1'b1;
        flush = 1'b1;
        flush_pc = 32'hBFC0_0400;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        flush = 1'b0;
        check("acc_fl_noreq", {31'd0, inst_req}, 32'd0);
        flush = 1'b1;
        flush_pc = 32'hBFC0_0500;
        @(negedge clk);
        flush = 1'b0;
        check("fl2_noreq", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata = 32'hBAD0_0001;
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("fl2_req", {31'd0, inst_req}, 32'd1);
        check("fl2_addr", inst_addr, 32'hBFC0_0500);
        fetch_one(0, 0, 0, 32'hBFC0_0500, mem_word(32'hBFC0_0500));

        // PC wraps from the top of the address space to zero.
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        flush = 1'b0;
        fetch_one(0, 0, 0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        check("wrap_addr", inst_addr, 32'h0000_0000);
        fetch_one(1, 1, 0, 32'h0000_0000, mem_word(32'h0000_0000));

`ifdef FETCH_ADDR_ERR_EN
        flush = 1'b1;
        flush_pc = 32'h0000_0002;
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ae_noreq", {31'd0, inst_req}, 32'd0);
        check("ae_pre_err", {31'd0, fetch_addr_err}, 32'd0);
        sb_q.push_back({32'h0000_0002, 32'h0000_0000});
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        check("ae_valid", {31'd0, id_valid}, 32'd1);
        check("ae_inst", id_inst, 32'h0000_0000);
        check("ae_pc", id_pc, 32'h0000_0002);
        check("ae_err", {31'd0, fetch_addr_err}, 32'd1);
        check("ae_post_noreq", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        check("ae_err_held", {31'd0, fetch_addr_err}, 32'd1);
`else
        flush = 1'b1;
        flush_pc = 32'hBFC0_0382;
        @(negedge clk);
        flush = 1'b0;
        check("align_req", {31'd0, inst_req}, 32'd1);
        check("align_addr", inst_addr, 32'hBFC0_0380);
`endif
        @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
